// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU use WIDTH shift-add steps; DIV/DIVU use WIDTH restoring
// shift-subtract steps on operand magnitudes, with the sign fix applied in a
// final cycle. MTHI/MTLO write HI/LO in one cycle.
//
// Handshake: start is sampled only while the FSM is in IDLE; busy is high
// from the edge that accepts a mul/div until the edge that writes hi/lo, and
// done pulses for exactly the one cycle in which hi/lo hold a new result.
//
// Optional feature: define MULDIV_CANCEL_EN to add the cancel port, which
// aborts an in-flight mul/div without touching hi/lo.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
`ifdef MULDIV_CANCEL_EN
   input  logic             cancel,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_busy;
   logic                r_done;
   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;
   logic [WIDTH-1:0]    r_x;       // raw dividend, returned in HI on divide by zero
   logic [WIDTH-1:0]    r_b;       // multiplicand / divisor magnitude
   logic [2*WIDTH:0]    r_acc;     // mul: {partial(W+1), multiplier}; div: {rem(W+1), quotient}
   logic [CW-1:0]       r_count;
   logic                r_is_div;
   logic                r_neg_q;   // product / quotient must be negated
   logic                r_neg_r;   // remainder must be negated (dividend sign)
   logic                r_dz;      // divisor was zero

   logic                w_cancel;
   logic                w_signed;
   logic                w_x_neg;
   logic                w_y_neg;
   logic [WIDTH-1:0]    w_x_mag;
   logic [WIDTH-1:0]    w_y_mag;
   logic [WIDTH:0]      w_mul_sum;
   logic [2*WIDTH:0]    w_mul_next;
   logic [2*WIDTH:0]    w_div_sh;
   logic [WIDTH:0]      w_div_sub;
   logic [2*WIDTH:0]    w_div_next;
   logic [2*WIDTH-1:0]  w_prod;
   logic [2*WIDTH-1:0]  w_prod_fix;
   logic [WIDTH-1:0]    w_quo_fix;
   logic [WIDTH-1:0]    w_rem_fix;

`ifdef MULDIV_CANCEL_EN
   assign w_cancel = cancel;
`else
   assign w_cancel = 1'b0;
`endif

   // Operand conditioning: signed ops work on magnitudes, signs kept aside.
   assign w_signed = (op == 3'd0) || (op == 3'd2);
   assign w_x_neg  = w_signed & x[WIDTH-1];
   assign w_y_neg  = w_signed & y[WIDTH-1];
   assign w_x_mag  = w_x_neg ? (-x) : x;
   assign w_y_mag  = w_y_neg ? (-y) : y;

   // Shift-add step: add multiplicand when the current multiplier bit is set,
   // then shift the whole accumulator right by one.
   assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
   assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring divide step: shift in the next dividend bit, try the subtract,
   // keep it only if it did not borrow.
   assign w_div_sh   = {r_acc[2*WIDTH-1:0], 1'b0};
   assign w_div_sub  = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_b};
   assign w_div_next = w_div_sub[WIDTH] ? w_div_sh
                                        : {w_div_sub, w_div_sh[WIDTH-1:1], 1'b1};

   // Sign fix applied to the finished magnitudes.
   assign w_prod     = r_acc[2*WIDTH-1:0];
   assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
   assign w_quo_fix  = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

   // Control FSM, datapath registers and HI/LO in one registered process.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_x      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                        r_is_div <= op[1];
                        r_x      <= x;
                        r_b      <= w_y_mag;
                        r_acc    <= {{(WIDTH+1){1'b0}}, w_x_mag};
                        r_neg_q  <= w_x_neg ^ w_y_neg;
                        r_neg_r  <= w_x_neg;
                        r_dz     <= (y == '0);
                     end
                     3'd4: begin
                        r_hi   <= x;
                        r_done <= 1'b1;
                     end
                     3'd5: begin
                        r_lo   <= x;
                        r_done <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               if (w_cancel) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc   <= r_is_div ? w_div_next : w_mul_next;
                  r_count <= r_count + CW'(1);
                  if (r_count == CW'(WIDTH - 1)) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               if (!w_cancel) begin
                  r_done <= 1'b1;
                  if (!r_is_div) begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end else if (r_dz) begin
                     r_hi <= r_x;
                     r_lo <= '1;
                  end else begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign dbg_state = r_state;

endmodule
